// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU start/done and writeback signals of the ALU sequencer
//   req_*  : decoded ALU request (valid/ready) from decode
//   alu_*  : operands, op and start/done handshake to the bit-serial ALU
//   wb_*   : writeback (valid/ready) toward the register file
//   busy, last_lat : status
//   modport master : the sequencer; modport slave : decode/ALU/writeback side
interface alu_sequencer_if #(parameter int LAT_W = 7);
  logic req_valid;
  logic req_ready;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [2:0] req_func3;
  logic req_func7b5;
  logic req_is_imm;
  logic [4:0] req_rd;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0] alu_op;
  logic alu_start;
  logic alu_done;
  logic [31:0] alu_rd;
  logic wb_valid;
  logic wb_ready;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic wb_err;
  logic busy;
  logic [LAT_W-1:0] last_lat;
  modport master (
    input req_valid, req_rs1, req_rs2, req_func3, req_func7b5, req_is_imm, req_rd,
    input alu_done, alu_rd, wb_ready,
    output req_ready, alu_rs1, alu_rs2, alu_op, alu_start,
    output wb_valid, wb_rd, wb_data, wb_err, busy, last_lat
  );
  modport slave (
    output req_valid, req_rs1, req_rs2, req_func3, req_func7b5, req_is_imm, req_rd,
    output alu_done, alu_rd, wb_ready,
    input req_ready, alu_rs1, alu_rs2, alu_op, alu_start,
    input wb_valid, wb_rd, wb_data, wb_err, busy, last_lat
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives one request at a time through the bit-serial ALU start/done handshake
//   clk, rst : clock and asynchronous active-high reset
//   bus      : alu_sequencer_if master (request in, ALU handshake, writeback out, busy/last_lat)
module alu_sequencer #(
  parameter int TIMEOUT = 80,
  parameter int LAT_W = 7
) (
  input logic clk,
  input logic rst,
  alu_sequencer_if.master bus
);
  typedef enum logic [2:0] {DRAIN, IDLE, SETUP, START, WAIT, WB, DRAIN_WB} state_t;
  state_t state, state_n;
  logic [LAT_W-1:0] cnt, cnt_inc, lat_q;
  logic [31:0] rs1_q, rs2_q, data_q;
  logic [3:0] op_q;
  logic [4:0] rd_q;
  logic err_q, b3, tmo;
  assign cnt_inc = cnt + 1'b1;
  assign tmo = cnt_inc == LAT_W'(TIMEOUT);
  // func7[5] selects SUB only for register ADD/SUB, and SRA/SRAI for the right shifts
  assign b3 = ((bus.req_func3 == 3'b000 && !bus.req_is_imm) || bus.req_func3 == 3'b101) ? bus.req_func7b5 : 1'b0;
  assign bus.alu_rs1 = rs1_q;
  assign bus.alu_rs2 = rs2_q;
  assign bus.alu_op = op_q;
  assign bus.wb_rd = rd_q;
  assign bus.wb_data = data_q;
  assign bus.wb_err = err_q;
  assign bus.last_lat = lat_q;
  always_comb begin
    state_n = state;
    bus.req_ready = state == IDLE;
    bus.alu_start = state == START;
    bus.wb_valid = state == WB || state == DRAIN_WB;
    bus.busy = state != IDLE;
    case (state)
      DRAIN: state_n = (bus.alu_done || tmo) ? IDLE : DRAIN;
      IDLE: state_n = !bus.req_valid ? IDLE : (bus.req_rd == 5'd0) ? WB : SETUP;
      SETUP: state_n = START;
      START: state_n = WAIT;
      WAIT: state_n = bus.alu_done ? WB : tmo ? DRAIN_WB : WAIT;
      WB: state_n = bus.wb_ready ? IDLE : WB;
      DRAIN_WB: state_n = bus.wb_ready ? DRAIN : DRAIN_WB;
      default: state_n = DRAIN;
    endcase
  end
  // a timed-out ALU may still be running, so it is drained again before the next request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DRAIN;
      cnt <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      lat_q <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == DRAIN || state == WAIT) ? cnt_inc : '0;
      if (state == IDLE && bus.req_valid) begin
        rs1_q <= bus.req_rs1;
        rs2_q <= bus.req_rs2;
        op_q <= {b3, bus.req_func3};
        rd_q <= bus.req_rd;
        data_q <= '0;
        err_q <= 1'b0;
      end
      if (state == WAIT && bus.alu_done) begin
        data_q <= bus.alu_rd;
        lat_q <= cnt_inc;
        err_q <= 1'b0;
      end else if (state == WAIT && tmo) begin
        data_q <= '0;
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven and directed checks of alu_sequencer against a bit-serial ALU model
module tb_alu_sequencer;
  localparam int TIMEOUT = 80;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_sequencer_if #(.LAT_W(7)) bus();
  alu_sequencer #(.TIMEOUT(TIMEOUT), .LAT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0] f3;
    logic f7;
    logic imm;
    logic [4:0] rd;
    logic [3:0] op;
    logic [31:0] data;
    logic [6:0] lat;
    int nstart;
  } vec_t;
  vec_t tv[11];
  int applied = 0;
  int miscompares = 0;
  int starts = 0;
  logic [3:0] op_seen = 4'h0;
  logic hang = 1'b0;
  logic [6:0] mcnt = 7'd0;
  logic [31:0] mres = 32'd0;
  // ALU model: 32 steps for add/logic, 63 for compares, 32+shamt for shifts; no reset
  function automatic logic [6:0] steps(input logic [3:0] op, input logic [31:0] b);
    case (op[2:0])
      3'b010, 3'b011: return 7'd63;
      3'b001, 3'b101: return 7'd32 + {2'b00, b[4:0]};
      default: return 7'd32;
    endcase
  endfunction
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (bus.alu_start && !hang) begin
      mcnt <= steps(bus.alu_op, bus.alu_rs2);
      mres <= alu(bus.alu_op, bus.alu_rs1, bus.alu_rs2);
    end else if (mcnt != 7'd0) mcnt <= mcnt - 7'd1;
    if (bus.alu_start) begin
      starts <= starts + 1;
      op_seen <= bus.alu_op;
    end
  end
  assign bus.alu_done = !hang && mcnt == 7'd1;
  assign bus.alu_rd = mres;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_wb(output int n);
    n = 0;
    while (!bus.wb_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic issue(input vec_t v);
    bus.req_rs1 = v.rs1;
    bus.req_rs2 = v.rs2;
    bus.req_func3 = v.f3;
    bus.req_func7b5 = v.f7;
    bus.req_is_imm = v.imm;
    bus.req_rd = v.rd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic pulse_wb_ready();
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int n, s0;
    wait_ready(n);
    chk("req_ready_rise", bus.req_ready, 1);
    s0 = starts;
    issue(v);
    wait_wb(n);
    chk("wb_valid", bus.wb_valid, 1);
    chk("wb_data", bus.wb_data, v.data);
    chk("wb_rd", bus.wb_rd, v.rd);
    chk("wb_err", bus.wb_err, 0);
    chk("start_pulses", starts - s0, v.nstart);
    if (v.nstart > 0) chk("alu_op", op_seen, v.op);
    chk("last_lat", bus.last_lat, v.lat);
    pulse_wb_ready();
  endtask
  task automatic check_drain(input string name);
    int bad = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (bus.req_ready || bus.wb_valid || bus.alu_start) bad++;
    end
    chk({name, "_quiet"}, bad, 0);
    @(negedge clk);
    chk({name, "_exit"}, bus.req_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, bad, s0;
    tv[0] = '{32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 5'd3, 4'h0, 32'd12, 7'd32, 1};
    tv[1] = '{32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 5'd4, 4'h8, 32'hFFFF_FFFE, 7'd32, 1};
    tv[2] = '{32'd5, 32'd7, 3'd0, 1'b1, 1'b1, 5'd5, 4'h0, 32'd12, 7'd32, 1};
    tv[3] = '{32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, 5'd6, 4'h2, 32'd1, 7'd63, 1};
    tv[4] = '{32'h8000_0000, 32'd4, 3'd5, 1'b1, 1'b1, 5'd7, 4'hD, 32'hF800_0000, 7'd36, 1};
    tv[5] = '{32'h8000_0000, 32'd4, 3'd5, 1'b0, 1'b1, 5'd8, 4'h5, 32'h0800_0000, 7'd36, 1};
    tv[6] = '{32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 1'b0, 5'd9, 4'h3, 32'd0, 7'd63, 1};
    tv[7] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 1'b0, 1'b0, 5'd10, 4'h4, 32'h0FF0_0FF0, 7'd32, 1};
    tv[8] = '{32'd1, 32'd31, 3'd1, 1'b0, 1'b0, 5'd31, 4'h1, 32'h8000_0000, 7'd63, 1};
    tv[9] = '{32'h1234_5678, 32'h0000_FFFF, 3'd7, 1'b1, 1'b0, 5'd11, 4'h7, 32'h0000_5678, 7'd32, 1};
    tv[10] = '{32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 7'd32, 0};
    bus.req_valid = 1'b0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_func3 = '0;
    bus.req_func7b5 = 1'b0;
    bus.req_is_imm = 1'b0;
    bus.req_rd = '0;
    bus.wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_err", bus.wb_err, 0);
    chk("rst_last_lat", bus.last_lat, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    rst = 1'b0;
    check_drain("drain_reset");
    chk("idle_busy", bus.busy, 0);
    for (int i = 0; i < 11; i++) run_vec(tv[i]);
    wait_ready(n);
    s0 = starts;
    issue('{32'd9, 32'd9, 3'd0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0, 7'd0, 0});
    chk("rd0_wb_next_cycle", bus.wb_valid, 1);
    chk("rd0_busy", bus.busy, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.wb_valid || bus.wb_data != 0 || bus.wb_rd != 0 || bus.wb_err || bus.req_ready || bus.alu_start) bad++;
    end
    chk("rd0_wb_hold", bad, 0);
    chk("rd0_no_start", starts - s0, 0);
    pulse_wb_ready();
    chk("rd0_back_idle", bus.req_ready, 1);
    chk("rd0_wb_drop", bus.wb_valid, 0);
    hang = 1'b1;
    s0 = starts;
    issue('{32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 5'd9, 4'h0, 32'd0, 7'd0, 0});
    wait_wb(n);
    chk("timeout_cycles", n, TIMEOUT + 2);
    chk("timeout_err", bus.wb_err, 1);
    chk("timeout_data", bus.wb_data, 0);
    chk("timeout_rd", bus.wb_rd, 9);
    chk("timeout_last_lat", bus.last_lat, 32);
    chk("timeout_starts", starts - s0, 1);
    repeat (3) @(negedge clk);
    chk("timeout_hold_err", bus.wb_err, 1);
    chk("timeout_hold_ready", bus.req_ready, 0);
    pulse_wb_ready();
    hang = 1'b0;
    check_drain("drain_timeout");
    run_vec(tv[0]);
    wait_ready(n);
    issue('{32'd5, 32'd7, 3'd0, 1'b0, 1'b0, 5'd13, 4'h0, 32'd0, 7'd0, 0});
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_rst_wb_valid", bus.wb_valid, 0);
    chk("midop_rst_last_lat", bus.last_lat, 0);
    chk("midop_rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    n = 0;
    bad = 0;
    while (!bus.req_ready && n < 2 * TIMEOUT) begin
      @(negedge clk);
      n++;
      if (bus.wb_valid || bus.alu_start) bad++;
    end
    chk("midop_no_writeback", bad, 0);
    chk("drain_done_exit", n, 27);
    run_vec(tv[3]);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
